mem_scan_ctrl: RTL and testbench
================================

// Module: mem_scan_ctrl
// PURPOSE
//  Sequencer for the lab instruction/data ROM (Memory: mem_addr[7:0] -> data[31:0]).
//  - Auto-steps the read address through the ROM at one of four button-selectable rates.
//  - Waits out the memory read latency, then latches each word into a display register.
//  - Supports pause/resume. Sits between the board buttons and the Memory + 7-seg display path.
// PARAMETERS
//  ADDR_W     8           memory address width
//  DATA_W     32          memory data width
//  DEPTH      128         words scanned; address wraps DEPTH-1 -> 0 (DEPTH <= 2**ADDR_W)
//  TICK_BASE  25_000_000  SHOW-phase cycles at speed 0; speed n uses TICK_BASE>>n (must be >= 8)
//  MEM_LAT    1           memory read latency in clk cycles, 0..3
// PORTS
//  clk         in   1       system clock
//  rst_n       in   1       reset, asynchronous, active-low
//  btn_pause   in   1       raw button, async; rising edge toggles pause
//  btn_faster  in   1       raw button, async; rising edge: speed_lvl+1, saturates at 3
//  btn_slower  in   1       raw button, async; rising edge: speed_lvl-1, saturates at 0
//  mem_data    in   DATA_W  read data from Memory
//  mem_addr    out  ADDR_W  read address to Memory
//  disp_data   out  DATA_W  latched word for the display
//  disp_valid  out  1       disp_data holds a captured word
//  speed_lvl   out  2       current speed level 0..3
//  paused      out  1       scan frozen
// BEHAVIOUR
//  Reset (async assert, sync release): mem_addr=0, disp_data=0, disp_valid=0, speed_lvl=0,
//   paused=0, state=FETCH, latency counter=0.
//  Buttons: each goes through a 2-FF synchronizer, then a rising-edge detector.
//   - One-cycle pulse 3 clks after the input rises. No debounce (done upstream).
//  FSM states: FETCH, SHOW, PAUSE.
//   FETCH: mem_addr stable; count MEM_LAT+1 cycles.
//    - On the last cycle, capture mem_data into disp_data and set disp_valid=1 (sticky until reset).
//    - Load timer = (TICK_BASE>>speed_lvl)-1, then go to SHOW.
//   SHOW: timer decrements each cycle.
//    - At timer==0: mem_addr <= (mem_addr==DEPTH-1) ? 0 : mem_addr+1, then go to FETCH.
//   Step period = MEM_LAT+1 + (TICK_BASE>>speed_lvl) cycles.
//   PAUSE: timer and mem_addr frozen; disp_data held.
//  Pause pulse:
//   - In SHOW: go to PAUSE (paused=1) the next cycle.
//   - In PAUSE: return to SHOW with the remaining timer (paused=0).
//   - In FETCH: the fetch completes, then the pause takes effect on entry to SHOW
//     (state goes directly to PAUSE); paused=1 from that cycle on.
//  Speed change: speed_lvl updates the next cycle; it affects only the next timer load.
//   The running count is not rescaled. Allowed while paused.
//  faster and slower pulses in the same cycle: both ignored.
//  Pause pulse coincident with SHOW timer==0: the step wins; pause applies at the next SHOW entry.
//  Reset mid-operation: all state returns to reset values at once; the scan restarts at address 0.
// STRUCTURE
//  Package mem_scan_pkg:
//   - state enum {FETCH, SHOW, PAUSE}
//   - SPEED_MAX=2'd3
//   - localparam function for timer width = $clog2(TICK_BASE)
//  Sub-module btn_edge (2-FF sync + rising-edge pulse, async active-low reset):
//   instantiated for pause, faster, slower.
//  Top: FSM, latency counter, step timer, address counter, speed register, display latch.
// TESTING  (TICK_BASE=16, MEM_LAT=1, DEPTH=8; model memory returns 32'hA000_0000+addr, 1-cycle latency)
//  1 Release reset -> disp_valid rises 2 cycles later with disp_data=A000_0000;
//    mem_addr steps 0,1,2.. every 18 cycles.
//  2 Run past addr 7 -> mem_addr wraps to 0, disp_data=A000_0000 again; no glitch value on mem_addr.
//  3 Pulse faster 4x -> speed_lvl saturates at 3; period 4 cycles after the next load.
//    Then slower 5x -> speed_lvl 0, period 18.
//  4 Pause mid-SHOW with timer=9 -> paused=1; mem_addr/disp_data frozen for 100 cycles.
//    Resume -> step occurs exactly 10 cycles later.
//  5 Pause during FETCH; also pause coincident with timer==0
//    -> fetch/step completes, then paused=1 on SHOW entry with disp_data updated.
//    Faster+slower same cycle -> speed_lvl unchanged.
//  6 Assert rst_n low mid-SHOW at addr 5 -> outputs zero asynchronously (same cycle).
//    Release -> scan restarts at 0, speed_lvl=0.

Source files
------------

// File: rtl/mem_scan_pkg.sv
// Shared types and constants for the ROM scan sequencer.
package mem_scan_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        SHOW  = 2'd1,
        PAUSE = 2'd2
    } scan_state_e;

    localparam logic [1:0] SPEED_MAX = 2'd3;

    // Width that holds TICK_BASE-1, the largest value ever loaded into the step timer.
    function automatic int timer_width(input int tick_base);
        return (tick_base > 1) ? $clog2(tick_base) : 1;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer for a raw button plus a registered one-cycle rising-edge pulse.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic prev;

    // NOTE: non-blocking assignments make every flop sample the pre-edge value, forming a true shift chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
            pulse <= sync2 & ~prev;
        end
    end

endmodule

// File: rtl/mem_scan_ctrl.sv
// ROM scan sequencer: steps mem_addr at a selectable rate, waits out read latency,
// latches each word for the display, and supports pause/resume from board buttons.
module mem_scan_ctrl
    import mem_scan_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 128,
    parameter int TICK_BASE = 25_000_000,
    parameter int MEM_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_pause,
    input  logic              btn_faster,
    input  logic              btn_slower,
    input  logic [DATA_W-1:0] mem_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic [1:0]        speed_lvl,
    output logic              paused
);

    localparam int              TW       = timer_width(TICK_BASE);
    localparam logic [1:0]      LAT_LAST = 2'(MEM_LAT);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    logic pause_p;
    logic faster_p;
    logic slower_p;

    btn_edge u_pause  (.clk(clk), .rst_n(rst_n), .btn(btn_pause),  .pulse(pause_p));
    btn_edge u_faster (.clk(clk), .rst_n(rst_n), .btn(btn_faster), .pulse(faster_p));
    btn_edge u_slower (.clk(clk), .rst_n(rst_n), .btn(btn_slower), .pulse(slower_p));

    scan_state_e       state, state_nxt;
    logic [1:0]        lat_cnt, lat_cnt_nxt;
    logic [TW-1:0]     timer, timer_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] disp_nxt;
    logic              valid_nxt;
    logic              pend, pend_nxt;
    logic [1:0]        speed_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            lat_cnt    <= '0;
            timer      <= '0;
            mem_addr   <= '0;
            disp_data  <= '0;
            disp_valid <= 1'b0;
            pend       <= 1'b0;
            speed_lvl  <= '0;
        end else begin
            state      <= state_nxt;
            lat_cnt    <= lat_cnt_nxt;
            timer      <= timer_nxt;
            mem_addr   <= addr_nxt;
            disp_data  <= disp_nxt;
            disp_valid <= valid_nxt;
            pend       <= pend_nxt;
            speed_lvl  <= speed_nxt;
        end
    end

    // NOTE: every output of this block gets a hold-value default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        lat_cnt_nxt = lat_cnt;
        timer_nxt   = timer;
        addr_nxt    = mem_addr;
        disp_nxt    = disp_data;
        valid_nxt   = disp_valid;
        pend_nxt    = pend;

        case (state)
            FETCH: begin
                // A pause requested mid-fetch is remembered and honoured on SHOW entry.
                if (pause_p) pend_nxt = ~pend;
                if (lat_cnt == LAT_LAST) begin
                    lat_cnt_nxt = '0;
                    disp_nxt    = mem_data;
                    valid_nxt   = 1'b1;
                    timer_nxt   = TW'((TICK_BASE >> speed_lvl) - 1);
                    pend_nxt    = 1'b0;
                    state_nxt   = (pend ^ pause_p) ? PAUSE : SHOW;
                end else begin
                    lat_cnt_nxt = lat_cnt + 2'd1;
                end
            end
            SHOW: begin
                // The step beats a coincident pause; the pause is carried into the next fetch.
                if (timer == '0) begin
                    addr_nxt  = (mem_addr == ADDR_LAST) ? '0 : mem_addr + ADDR_W'(1);
                    pend_nxt  = pause_p;
                    state_nxt = FETCH;
                end else if (pause_p) begin
                    state_nxt = PAUSE;
                end else begin
                    timer_nxt = timer - TW'(1);
                end
            end
            PAUSE: begin
                if (pause_p) state_nxt = SHOW;
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_comb begin
        speed_nxt = speed_lvl;
        if (faster_p && !slower_p && speed_lvl != SPEED_MAX) begin
            speed_nxt = speed_lvl + 2'd1;
        end else if (slower_p && !faster_p && speed_lvl != 2'd0) begin
            speed_nxt = speed_lvl - 2'd1;
        end
    end

    assign paused = (state == PAUSE);

endmodule

// File: tb/tb_mem_scan_ctrl.sv
// Self-checking bench for mem_scan_ctrl: directed scenarios plus random button traffic,
// all compared each cycle against a phase/countdown reference model.
module tb_mem_scan_ctrl;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 32;
    localparam int DEPTH     = 8;
    localparam int TICK_BASE = 16;
    localparam int MEM_LAT   = 1;
    localparam logic [31:0] ROM_BASE = 32'hA000_0000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              btn_pause = 1'b0;
    logic              btn_faster = 1'b0;
    logic              btn_slower = 1'b0;
    logic [DATA_W-1:0] mem_data;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic [1:0]        speed_lvl;
    logic              paused;

    mem_scan_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .TICK_BASE(TICK_BASE), .MEM_LAT(MEM_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_pause(btn_pause), .btn_faster(btn_faster), .btn_slower(btn_slower),
        .mem_data(mem_data), .mem_addr(mem_addr),
        .disp_data(disp_data), .disp_valid(disp_valid),
        .speed_lvl(speed_lvl), .paused(paused)
    );

    always #5 clk = ~clk;

    // ROM with one cycle of read latency.
    always @(posedge clk) mem_data <= ROM_BASE + 32'(mem_addr);

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: remaining fetch cycles, remaining show cycles, pause flags.
    int          fetch_left, show_left, m_addr, m_speed;
    bit          m_paused, m_pend, m_valid;
    logic [31:0] m_disp;
    bit   [4:0]  hp, hf, hs;

    task automatic model_reset();
        fetch_left = MEM_LAT + 1;
        show_left  = 0;
        m_addr     = 0;
        m_speed    = 0;
        m_paused   = 0;
        m_pend     = 0;
        m_valid    = 0;
        m_disp     = '0;
        hp = '0; hf = '0; hs = '0;
    endtask

    task automatic model_edge();
        bit pp, pf, ps;
        int old_speed;
        hp = {hp[3:0], btn_pause};
        hf = {hf[3:0], btn_faster};
        hs = {hs[3:0], btn_slower};
        // A press acts on the third clock edge after the pin is first sampled high.
        pp = hp[3] & ~hp[4];
        pf = hf[3] & ~hf[4];
        ps = hs[3] & ~hs[4];
        old_speed = m_speed;
        if (fetch_left > 0) begin
            if (pp) m_pend = !m_pend;
            fetch_left--;
            if (fetch_left == 0) begin
                m_disp    = ROM_BASE + 32'(m_addr);
                m_valid   = 1;
                show_left = TICK_BASE >> old_speed;
                if (m_pend) begin
                    m_paused = 1;
                    m_pend   = 0;
                end
            end
        end else if (m_paused) begin
            if (pp) m_paused = 0;
        end else if (show_left == 1) begin
            m_addr     = (m_addr + 1) % DEPTH;
            fetch_left = MEM_LAT + 1;
            show_left  = 0;
            m_pend     = pp;
        end else if (pp) begin
            m_paused = 1;
        end else begin
            show_left--;
        end
        if (pf && !ps) m_speed = (m_speed < 3) ? m_speed + 1 : 3;
        else if (ps && !pf) m_speed = (m_speed > 0) ? m_speed - 1 : 0;
    endtask

    task automatic compare_all();
        check("mem_addr",   32'(mem_addr),   32'(m_addr));
        check("disp_data",  disp_data,       m_disp);
        check("disp_valid", 32'(disp_valid), 32'(m_valid));
        check("speed_lvl",  32'(speed_lvl),  32'(m_speed));
        check("paused",     32'(paused),     32'(m_paused));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic press(input logic p, input logic f, input logic s);
        btn_pause = p; btn_faster = f; btn_slower = s;
        tick(); tick();
        btn_pause = 0; btn_faster = 0; btn_slower = 0;
        tick(); tick();
    endtask

    // Ticks until mem_addr changes; n is the number of ticks taken.
    task automatic run_to_step(output int n);
        logic [ADDR_W-1:0] a0;
        a0 = mem_addr;
        n = 0;
        while (mem_addr == a0 && n < 400) begin
            tick();
            n++;
        end
        check("step_timeout", 32'(n >= 400), 32'd0);
    endtask

    task automatic wait_show(input int left, input int addr);
        int n;
        n = 0;
        while (!(fetch_left == 0 && !m_paused && show_left == left &&
                 (addr < 0 || m_addr == addr)) && n < 1000) begin
            tick();
            n++;
        end
        check("wait_timeout", 32'(n >= 1000), 32'd0);
    endtask

    function automatic logic rnd_btn(input logic cur);
        return cur ? ($urandom_range(2) != 0) : ($urandom_range(40) == 0);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int exp_addr;
        logic [31:0] exp_disp;

        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_addr",  32'(mem_addr),   32'd0);
        check("rst_disp",  disp_data,       32'd0);
        check("rst_valid", 32'(disp_valid), 32'd0);
        check("rst_speed", 32'(speed_lvl),  32'd0);
        check("rst_pause", 32'(paused),     32'd0);

        // Scenario 1: first capture two cycles after release, then 18-cycle steps.
        tick();
        check("valid_1cyc", 32'(disp_valid), 32'd0);
        tick();
        check("valid_2cyc", 32'(disp_valid), 32'd1);
        check("first_word", disp_data, ROM_BASE);
        run_to_step(n);
        run_to_step(n);
        check("period_spd0", 32'(n), 32'd18);

        // Scenario 2: wrap from DEPTH-1 back to 0.
        wait_show(5, DEPTH - 1);
        run_to_step(n);
        check("wrap_addr", 32'(mem_addr), 32'd0);
        tick(); tick();
        check("wrap_disp", disp_data, ROM_BASE);

        // Scenario 3: speed saturation both ways and resulting periods.
        repeat (4) press(0, 1, 0);
        check("speed_sat_hi", 32'(speed_lvl), 32'd3);
        run_to_step(n);
        run_to_step(n);
        check("period_spd3", 32'(n), 32'd4);
        repeat (5) press(0, 0, 1);
        check("speed_sat_lo", 32'(speed_lvl), 32'd0);
        run_to_step(n);
        run_to_step(n);
        check("period_spd0b", 32'(n), 32'd18);

        // Scenario 4: pause with timer=9, hold 100 cycles, resume -> step 10 cycles after.
        wait_show(13, -1);
        press(1, 0, 0);
        check("pause_show", 32'(paused), 32'd1);
        exp_addr = m_addr;
        exp_disp = ROM_BASE + 32'(exp_addr);
        repeat (100) tick();
        check("frozen_addr", 32'(mem_addr), 32'(exp_addr));
        check("frozen_disp", disp_data, exp_disp);
        btn_pause = 1'b1;
        n = 0;
        while (mem_addr == ADDR_W'(exp_addr) && n < 200) begin
            if (n == 2) btn_pause = 1'b0;
            tick();
            n++;
        end
        btn_pause = 1'b0;
        check("resume_step", 32'(n), 32'd14);

        // Scenario 5: pause landing in FETCH, and pause coincident with timer==0.
        wait_show(3, -1);
        exp_addr = (m_addr + 1) % DEPTH;
        press(1, 0, 0);
        tick();
        check("pause_fetch", 32'(paused), 32'd1);
        check("pause_fetch_disp", disp_data, ROM_BASE + 32'(exp_addr));
        press(1, 0, 0);
        check("unpause_fetch", 32'(paused), 32'd0);
        wait_show(4, -1);
        exp_addr = (m_addr + 1) % DEPTH;
        press(1, 0, 0);
        check("coinc_addr", 32'(mem_addr), 32'(exp_addr));
        tick(); tick();
        check("pause_coinc", 32'(paused), 32'd1);
        check("pause_coinc_disp", disp_data, ROM_BASE + 32'(exp_addr));
        press(0, 1, 1);
        check("speed_both", 32'(speed_lvl), 32'd0);
        press(1, 0, 0);

        // Scenario 6: asynchronous reset mid-SHOW at address 5.
        press(0, 1, 0);
        press(0, 1, 0);
        wait_show(3, 5);
        #2 rst_n = 1'b0;
        #1;
        check("arst_addr",  32'(mem_addr),   32'd0);
        check("arst_disp",  disp_data,       32'd0);
        check("arst_valid", 32'(disp_valid), 32'd0);
        check("arst_speed", 32'(speed_lvl),  32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        compare_all();
        run_to_step(n);
        check("restart_addr", 32'(mem_addr), 32'd1);
        check("restart_period", 32'(n), 32'd18);

        // Random button traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            btn_pause  = rnd_btn(btn_pause);
            btn_faster = rnd_btn(btn_faster);
            btn_slower = rnd_btn(btn_slower);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
